// File: rtl/fx2_pipe.sv
// FX2 shift/rotate execution pipe: stage 1 registers operands, stage 2 the result, then delay to wb.
// Optional forwarding taps on stages 2..LATENCY are enabled by defining FX2_PIPE_FWD_EN.
`timescale 1ns / 1ps

module fx2_pipe #(
    parameter int unsigned LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [2:0]                  issue_op,
    input  logic [6:0]                  issue_rt,
    input  logic [127:0]                ra,
    input  logic [127:0]                rb,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        wb_valid,
    output logic [6:0]                  wb_rt,
    output logic [127:0]                wb_result,
    output logic [3:0]                  inflight
`ifdef FX2_PIPE_FWD_EN
    ,
    output logic [LATENCY-2:0]          fwd_valid,
    output logic [7*(LATENCY-1)-1:0]    fwd_rt,
    output logic [128*(LATENCY-1)-1:0]  fwd_result
`endif
);

    localparam logic [2:0] OP_ROTH = 3'b000;
    localparam logic [2:0] OP_ROT  = 3'b001;
    localparam logic [2:0] OP_SHLH = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;

    // r_valid[k] is the valid bit of stage k+1
    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] w_valid_d;
    logic [2:0]         r_op;
    logic [127:0]       r_ra;
    logic [127:0]       r_rb;
    logic [6:0]         r_rt  [LATENCY];
    logic [127:0]       r_res [LATENCY-1];
    logic [3:0]         r_inflight;
    logic [127:0]       w_result;
    logic               w_accept;
    logic               w_unused_rb;

    assign issue_ready = ~stall;
    assign w_accept    = issue_valid & ~stall & ~flush;
    assign w_unused_rb = ^r_rb;

    always_comb begin
        w_valid_d = r_valid;
        if (flush) begin
            w_valid_d = '0;
        end else if (!stall) begin
            w_valid_d = {r_valid[LATENCY-2:0], w_accept};
        end
    end

    // Vectors are [127:0] with bit 127 = big-endian bit 0, so element e sits at [127-W*e -: W]
    always_comb begin : compute
        logic [15:0] v_hw;
        logic [4:0]  v_hs;
        logic [31:0] v_wd;
        logic [5:0]  v_ws;
        v_hw     = '0;
        v_hs     = '0;
        v_wd     = '0;
        v_ws     = '0;
        w_result = '0;
        case (r_op)
            OP_ROTH: begin
                for (int h = 0; h < 8; h++) begin
                    v_hw = r_ra[127-16*h -: 16];
                    v_hs = {1'b0, r_rb[115-16*h -: 4]};
                    w_result[127-16*h -: 16] = (v_hw << v_hs) | (v_hw >> (5'd16 - v_hs));
                end
            end
            OP_SHLH: begin
                for (int h = 0; h < 8; h++) begin
                    v_hw = r_ra[127-16*h -: 16];
                    v_hs = r_rb[116-16*h -: 5];
                    w_result[127-16*h -: 16] = v_hs[4] ? 16'h0 : (v_hw << v_hs[3:0]);
                end
            end
            OP_ROT: begin
                for (int w = 0; w < 4; w++) begin
                    v_wd = r_ra[127-32*w -: 32];
                    v_ws = {1'b0, r_rb[100-32*w -: 5]};
                    w_result[127-32*w -: 32] = (v_wd << v_ws) | (v_wd >> (6'd32 - v_ws));
                end
            end
            OP_SHL: begin
                for (int w = 0; w < 4; w++) begin
                    v_wd = r_ra[127-32*w -: 32];
                    v_ws = r_rb[101-32*w -: 6];
                    w_result[127-32*w -: 32] = v_ws[5] ? 32'h0 : (v_wd << v_ws[4:0]);
                end
            end
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_inflight <= '0;
            r_op       <= '0;
            r_ra       <= '0;
            r_rb       <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_rt[k] <= '0;
            end
            for (int j = 0; j < LATENCY - 1; j++) begin
                r_res[j] <= '0;
            end
        end else begin
            r_valid    <= w_valid_d;
            r_inflight <= 4'($countones(w_valid_d));
            if (!stall) begin
                r_op    <= issue_op;
                r_ra    <= ra;
                r_rb    <= rb;
                r_rt[0] <= issue_rt;
                for (int k = 1; k < LATENCY; k++) begin
                    r_rt[k] <= r_rt[k-1];
                end
                r_res[0] <= w_result;
                for (int j = 1; j < LATENCY - 1; j++) begin
                    r_res[j] <= r_res[j-1];
                end
            end
        end
    end

    assign wb_valid  = r_valid[LATENCY-1] & ~stall & ~flush;
    assign wb_rt     = r_rt[LATENCY-1];
    assign wb_result = r_res[LATENCY-2];
    assign inflight  = r_inflight;

`ifdef FX2_PIPE_FWD_EN
    // Slot k (0 = LSB) carries stage LATENCY-k, so stage 2 lands in the MSB slot
    for (genvar k = 0; k < LATENCY - 1; k++) begin : g_fwd
        assign fwd_valid[k]             = r_valid[LATENCY-1-k];
        assign fwd_rt[7*k +: 7]         = r_rt[LATENCY-1-k];
        assign fwd_result[128*k +: 128] = r_res[LATENCY-2-k];
    end
`endif

endmodule

// File: tb/tb_fx2_pipe.sv
// Scoreboard bench for fx2_pipe: expected writebacks are queued at issue with a due cycle.
`timescale 1ns / 1ps

module tb_fx2_pipe;

    localparam int unsigned LAT = 4;

    logic         clk;
    logic         rst_n;
    logic         issue_valid;
    logic         issue_ready;
    logic [2:0]   issue_op;
    logic [6:0]   issue_rt;
    logic [127:0] ra;
    logic [127:0] rb;
    logic         stall;
    logic         flush;
    logic         wb_valid;
    logic [6:0]   wb_rt;
    logic [127:0] wb_result;
    logic [3:0]   inflight;
`ifdef FX2_PIPE_FWD_EN
    logic [LAT-2:0]         fwd_valid;
    logic [7*(LAT-1)-1:0]   fwd_rt;
    logic [128*(LAT-1)-1:0] fwd_result;
`endif

    fx2_pipe #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_rt   (issue_rt),
        .ra         (ra),
        .rb         (rb),
        .stall      (stall),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_rt      (wb_rt),
        .wb_result  (wb_result),
        .inflight   (inflight)
`ifdef FX2_PIPE_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rt     (fwd_rt),
        .fwd_result (fwd_result)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   rt;
        logic [127:0] res;
        int           key;
    } ent_t;

    ent_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   stall_tot = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit-level reference: element LSB at LE index base, rotate/shift done one bit at a time
    function automatic logic [127:0] model(input logic [2:0] op, input logic [127:0] a,
                                           input logic [127:0] b);
        logic [127:0] y;
        int n, s, base;
        bit rot;
        y = '0;
        if (op > 3'd3) return y;
        n   = op[0] ? 32 : 16;
        rot = !op[1];
        for (int e = 0; e < 128 / n; e++) begin
            base = 127 - n * e - (n - 1);
            if (n == 16) s = rot ? int'(b[base +: 4]) : int'(b[base +: 5]);
            else         s = rot ? int'(b[base +: 5]) : int'(b[base +: 6]);
            for (int j = 0; j < n; j++) begin
                if (rot)         y[base + j] = a[base + ((j - s + n) % n)];
                else if (j >= s) y[base + j] = a[base + j - s];
                else             y[base + j] = 1'b0;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input logic v, input logic [2:0] op, input logic [6:0] rt,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic st, input logic fl);
        logic exp_wb;
        ent_t e;
        @(negedge clk);
        issue_valid = v;
        issue_op    = op;
        issue_rt    = rt;
        ra          = a;
        rb          = b;
        stall       = st;
        flush       = fl;
        #1;
        check("issue_ready", issue_ready, !st);
        check("inflight", inflight, q.size());
        exp_wb = (q.size() > 0) && (q[0].key + stall_tot == cyc) && !st && !fl;
        check("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check("wb_rt", wb_rt, q[0].rt);
            check("wb_result", wb_result, q[0].res);
            void'(q.pop_front());
        end
        if (fl) begin
            q.delete();
        end else if (v && !st) begin
            e.rt  = rt;
            e.res = model(op, a, b);
            e.key = cyc + LAT - stall_tot;
            q.push_back(e);
        end
        if (st) stall_tot++;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 7'd0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] rt,
                         input logic [127:0] a, input logic [127:0] b);
        step(1'b1, op, rt, a, b, 1'b0, 1'b0);
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_rt    = '0;
        ra          = '0;
        rb          = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        #2;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rt", wb_rt, 0);
        check("rst_wb_result", wb_result, 0);
        check("rst_inflight", inflight, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ops, back to back, followed by a reserved opcode
        a = rnd128(); b = rnd128();
        a[127 -: 16] = 16'h8001; b[127 -: 16] = 16'h0001;
        issue(3'b000, 7'd5, a, b);
        a = rnd128(); b = rnd128();
        a[127 -: 32] = 32'h8000_0001; b[127 -: 32] = 32'h0000_0024;
        issue(3'b001, 7'd6, a, b);
        a = rnd128(); b = rnd128();
        a[127 -: 16] = 16'h00FF; b[127 -: 16] = 16'd17;
        issue(3'b010, 7'd7, a, b);
        a = rnd128(); b = rnd128();
        a[127 -: 32] = 32'h1; b[127 -: 32] = 32'd31;
        issue(3'b011, 7'd8, a, b);
        issue(3'b101, 7'd127, rnd128(), rnd128());
        idle(LAT + 2);

        // Stall for two cycles while the instruction sits in the last stage
        issue(3'b001, 7'd9, rnd128(), rnd128());
        idle(LAT - 1);
        step(1'b1, 3'b000, 7'd10, rnd128(), rnd128(), 1'b1, 1'b0);
        step(1'b1, 3'b010, 7'd11, rnd128(), rnd128(), 1'b1, 1'b0);
        idle(LAT + 1);

        // Flush with three in flight plus a same-cycle issue
        issue(3'b000, 7'd20, rnd128(), rnd128());
        issue(3'b001, 7'd21, rnd128(), rnd128());
        issue(3'b011, 7'd22, rnd128(), rnd128());
        step(1'b1, 3'b010, 7'd23, rnd128(), rnd128(), 1'b0, 1'b1);
        idle(LAT + 2);

        // Random traffic with bubbles, stalls and flushes
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 7'($urandom),
                 rnd128(), rnd128(), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 15) == 0));
        end
        idle(LAT + 2);

        // Asynchronous reset while a writeback is being presented
        for (int i = 0; i < 5; i++) issue(3'($urandom_range(0, 3)), 7'(40 + i), rnd128(), rnd128());
        idle(2);
        step(1'b0, 3'd0, 7'd0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_wb_valid", wb_valid, 0);
        check("async_rst_inflight", inflight, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;

        for (int i = 0; i < 6; i++) issue(3'($urandom_range(0, 4)), 7'(60 + i), rnd128(), rnd128());
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
